// File: rtl/alu_result_packer.sv
// Packs four ALU decoder results (sel 0..3) into one frame, checks sequence order, buffers frames.
// Optional frame consistency checking is built when ALU_PACK_CHECK_EN is defined.
module alu_result_packer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_result,
  input  logic [1:0]          in_sel,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DATA_W-1:0] out_frame,
  output logic                seq_err,
  output logic [7:0]          drop_cnt,
  output logic                chk_err
);
  // state | meaning
  // WAIT0 | idle, waiting for a sel 0 result to start a frame
  // GOT0  | lane0 held, expecting sel 1
  // GOT1  | lanes 0..1 held, expecting sel 2
  // GOT2  | lanes 0..2 held, expecting sel 3 to complete the frame
  typedef enum logic [1:0] {WAIT0, GOT0, GOT1, GOT2} state_t;

  localparam int PW = $clog2(DEPTH);

  state_t              state;
  logic [DATA_W-1:0]   lane0, lane1, lane2;
  logic [4*DATA_W-1:0] mem [DEPTH];
  logic [PW:0]         wr_ptr, rd_ptr;
  logic                empty, full, pop, frame_done, push;
  logic [4*DATA_W-1:0] frame_data;

  assign frame_done = in_valid && (state == GOT2) && (in_sel == 2'd3);
  assign frame_data = {in_result, lane2, lane1, lane0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= WAIT0;
      lane0   <= '0;
      lane1   <= '0;
      lane2   <= '0;
      seq_err <= 1'b0;
    end else begin
      seq_err <= 1'b0;
      if (in_valid) begin
        case (state)
          WAIT0: begin
            if (in_sel == 2'd0) begin
              lane0 <= in_result;
              state <= GOT0;
            end else begin
              seq_err <= 1'b1;
            end
          end
          GOT0: begin
            if (in_sel == 2'd1) begin
              lane1 <= in_result;
              state <= GOT1;
            end else begin
              seq_err <= 1'b1;
              if (in_sel == 2'd0) lane0 <= in_result;
              state <= (in_sel == 2'd0) ? GOT0 : WAIT0;
            end
          end
          GOT1: begin
            if (in_sel == 2'd2) begin
              lane2 <= in_result;
              state <= GOT2;
            end else begin
              seq_err <= 1'b1;
              if (in_sel == 2'd0) lane0 <= in_result;
              state <= (in_sel == 2'd0) ? GOT0 : WAIT0;
            end
          end
          default: begin
            // sel 3 completes the frame; the push itself happens in the FIFO block
            if (in_sel != 2'd3) begin
              seq_err <= 1'b1;
              if (in_sel == 2'd0) lane0 <= in_result;
              state <= (in_sel == 2'd0) ? GOT0 : WAIT0;
            end else begin
              state <= WAIT0;
            end
          end
        endcase
      end
    end
  end

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign out_valid = !empty;
  assign out_frame = empty ? '0 : mem[rd_ptr[PW-1:0]];
  assign pop       = out_valid && out_ready;
  // when full, a same-edge pop frees the slot the new frame overwrites
  assign push      = frame_done && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      drop_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (frame_done && !push && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= frame_data;
  end

`ifdef ALU_PACK_CHECK_EN
  logic frame_bad;
  always_comb begin
    frame_bad = 1'b0;
    if (in_result > DATA_W'(1))                 frame_bad = 1'b1;
    if ((lane1 & lane2) != lane2)               frame_bad = 1'b1;
    if ((lane1 == '0) && (in_result != '0))     frame_bad = 1'b1;
    if ((lane0 != '0) && (in_result != DATA_W'(1))) frame_bad = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chk_err <= 1'b0;
    else        chk_err <= frame_done && frame_bad;
  end
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_packer.sv
// Randomized bench for alu_result_packer against a queue-based reference model.
module tb_alu_result_packer;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_result = '0;
  logic [1:0]  in_sel = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_frame;
  logic        seq_err;
  logic [7:0]  drop_cnt;
  logic        chk_err;

  alu_result_packer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_result(in_result),
    .in_sel(in_sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_frame(out_frame), .seq_err(seq_err), .drop_cnt(drop_cnt), .chk_err(chk_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model: partial frame as a list of results, FIFO as a list of frames
  int          part[$];
  logic [31:0] fq[$];
  int          drops = 0;
  bit          exp_seq = 0;
  bit          exp_chk = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit frame_bad(input logic [31:0] f);
    logic [7:0] l0, l1, l2, l3;
    {l3, l2, l1, l0} = f;
    return (l3 > 1) || ((l1 & l2) != l2) || (l1 == 0 && l3 != 0) || (l0 != 0 && l3 != 1);
  endfunction

  task automatic model_reset();
    part.delete();
    fq.delete();
    drops = 0;
    exp_seq = 0;
    exp_chk = 0;
  endtask

  task automatic model_edge(input bit v, input int sel, input int res, input bit rdy);
    bit          done = 0;
    logic [31:0] f = '0;
    exp_seq = 0;
    exp_chk = 0;
    if (v) begin
      if (sel == part.size()) begin
        part.push_back(res);
        if (part.size() == 4) begin
          f = {part[3][7:0], part[2][7:0], part[1][7:0], part[0][7:0]};
          done = 1;
          part.delete();
        end
      end else begin
        exp_seq = 1;
        part.delete();
        if (sel == 0) part.push_back(res);
      end
    end
    if (fq.size() > 0 && rdy) void'(fq.pop_front());
    if (done) begin
`ifdef ALU_PACK_CHECK_EN
      exp_chk = frame_bad(f);
`endif
      if (fq.size() < DEPTH) fq.push_back(f);
      else if (drops < 255) drops++;
    end
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, ".valid"}, out_valid, fq.size() > 0);
    check_val({tag, ".frame"}, out_frame, fq.size() > 0 ? fq[0] : 32'h0);
    check_val({tag, ".seq_err"}, seq_err, exp_seq);
    check_val({tag, ".chk_err"}, chk_err, exp_chk);
    check_val({tag, ".drop_cnt"}, drop_cnt, drops);
  endtask

  // called at a negedge: drive, let the edge happen, check at the next negedge
  task automatic step(input string tag, input bit v, input int sel, input int res, input bit rdy);
    in_valid  = v;
    in_sel    = sel[1:0];
    in_result = res[7:0];
    out_ready = rdy;
    model_edge(v, sel, res, rdy);
    @(posedge clk);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic send_frame(input string tag, input int r0, input int r1, input int r2,
                            input int r3, input bit rdy);
    step(tag, 1, 0, r0, rdy);
    step(tag, 1, 1, r1, rdy);
    step(tag, 1, 2, r2, rdy);
    step(tag, 1, 3, r3, rdy);
  endtask

  initial begin
    @(negedge clk);
    #1;
    check_val("rst.valid", out_valid, 0);
    check_val("rst.frame", out_frame, 0);
    check_val("rst.drop", drop_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // operands 3 and 5: mult, or, and, logical-and
    send_frame("op3x5", 8'h0F, 8'h07, 8'h01, 8'h01, 0);
    check_val("op3x5.frame_const", out_frame, 32'h0101070F);
    check_val("op3x5.valid_const", out_valid, 1);
    step("drain", 0, 0, 0, 1);

    // 0,1,3 is a violation, then a clean frame
    step("skip2", 1, 0, 8'h11, 1);
    step("skip2", 1, 1, 8'h22, 1);
    step("skip2", 1, 3, 8'h33, 1);
    check_val("skip2.seq_pulse", seq_err, 1);
    check_val("skip2.no_push", out_valid, 0);
    send_frame("after_skip", 8'h01, 8'h02, 8'h03, 8'h04, 0);
    step("drain", 0, 0, 0, 1);

    // 0,1,0 restarts with the second 0
    step("restart", 1, 0, 8'hA1, 1);
    step("restart", 1, 1, 8'hB2, 1);
    step("restart", 1, 0, 8'hC3, 1);
    step("restart", 1, 1, 8'hD4, 0);
    step("restart", 1, 2, 8'hE5, 0);
    step("restart", 1, 3, 8'hF6, 0);
    check_val("restart.frame_const", out_frame, 32'hF6E5D4C3);
    step("drain", 0, 0, 0, 1);

    // six frames into a 4-deep FIFO with the consumer stalled
    for (int i = 0; i < 6; i++) send_frame("fill", i, i + 16, i + 32, i + 48, 0);
    check_val("fill.drop_const", drop_cnt, 2);
    for (int i = 0; i < 5; i++) step("popall", 0, 0, 0, 1);
    check_val("popall.empty", out_valid, 0);

    // full FIFO, pop and completion on the same edge
    for (int i = 0; i < 4; i++) send_frame("refill", 8'h40 + i, 1, 2, 3, 0);
    step("fullpp", 1, 0, 8'h50, 0);
    step("fullpp", 1, 1, 8'h51, 0);
    step("fullpp", 1, 2, 8'h52, 0);
    step("fullpp", 1, 3, 8'h53, 1);
    check_val("fullpp.drop_const", drop_cnt, 2);
    check_val("fullpp.occupancy", fq.size(), 4);
    for (int i = 0; i < 5; i++) step("popall2", 0, 0, 0, 1);

    // frame that violates the consistency rules
    send_frame("chk", 8'h00, 8'h03, 8'h04, 8'h00, 1);
`ifdef ALU_PACK_CHECK_EN
    check_val("chk.pulse", chk_err, 1);
`else
    check_val("chk.tied", chk_err, 0);
`endif
    check_val("chk.frame_const", out_frame, 32'h00040300);
    step("drain", 0, 0, 0, 1);

    // randomized traffic, mostly in order with occasional misordering
    for (int i = 0; i < 3000; i++) begin
      bit v   = ($urandom_range(0, 3) != 0);
      int sel = ($urandom_range(0, 7) < 6) ? (part.size() % 4) : $urandom_range(0, 3);
      int res = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1) : $urandom_range(0, 255);
      bit rdy = ($urandom_range(0, 2) == 0);
      step("rand", v, sel, res, rdy);
    end

    // asynchronous reset mid-frame with frames buffered
    send_frame("prerst", 1, 2, 3, 4, 0);
    step("prerst", 1, 0, 8'h77, 0);
    step("prerst", 1, 1, 8'h78, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst.valid", out_valid, 0);
    check_val("arst.frame", out_frame, 0);
    check_val("arst.seq", seq_err, 0);
    check_val("arst.chk", chk_err, 0);
    check_val("arst.drop", drop_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step("postrst", 1, 2, 8'h99, 1);
    check_val("postrst.partial_gone", seq_err, 1);
    send_frame("postrst", 9, 8, 7, 6, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end
endmodule
